// File: rtl/dual_port_ram_clr.sv
// Simple-dual-port RAM with per-lane write enables, a post-reset clear sequencer,
// selectable read latency (1/2) and selectable read-during-write behaviour.
module dual_port_ram_clr #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADD_WIDTH  = 4,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int unsigned LANES = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [LANES-1:0]      wr_be,
  input  logic [ADD_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADD_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int unsigned DEPTH = 2 ** ADD_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                 state_q, state_d;
  logic [ADD_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                   clr_we;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   wr_fire, rd_fire;
  logic [DATA_WIDTH-1:0]  wr_merged, rd_word;
  logic                   s1_valid_q;
  logic [DATA_WIDTH-1:0]  s1_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + ADD_WIDTH'(1);
        if (&clr_cnt_q) state_d = StReady;
      end
      StReady: ;
      default: state_d = StClear;
    endcase
  end

  assign busy    = (state_q == StClear);
  assign wr_fire = wr_en && !busy && !reset;
  assign rd_fire = rd_en && !busy;

  // Memory contents are never reset; only the sequencer or the write port touch them.
  always_ff @(posedge clk) begin
    if (clr_we && !reset) begin
      mem[clr_cnt_q] <= CLEAR_VALUE;
    end else if (wr_fire) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Word as it will look after this cycle's write; used for write-through reads.
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_be[i]) wr_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_comb begin
    rd_word = mem[rd_addr];
    if ((RDW_MODE == 1) && wr_fire && (wr_addr == rd_addr)) rd_word = wr_merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_fire;
      if (rd_fire) s1_data_q <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Scoreboard bench: two RAM instances (latency 1 / read-first, latency 2 / write-through)
// share one directed stimulus stream; a monitor checks data and arrival edge of every read.
module tb_dual_port_ram_clr;

  localparam logic [31:0] CLR_A = 32'h0000_00A5;
  localparam logic [31:0] CLR_B = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        busy_a, busy_b, valid_a, valid_b;
  logic [31:0] data_a, data_b;

  dual_port_ram_clr #(
    .DATA_WIDTH(32), .ADD_WIDTH(4), .BYTE_WIDTH(8),
    .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_VALUE(CLR_A)
  ) u_dut_a (
    .clk(clk), .reset(reset), .busy(busy_a),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_a), .rd_valid(valid_a)
  );

  dual_port_ram_clr #(
    .DATA_WIDTH(32), .ADD_WIDTH(4), .BYTE_WIDTH(8),
    .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_VALUE(CLR_B)
  ) u_dut_b (
    .clk(clk), .reset(reset), .busy(busy_b),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_b), .rd_valid(valid_b)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: edge %0d", name, edge_n);
  endtask

  // Samples at the falling edge; edge_n then names the rising edge just taken.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_a) begin
        if (qa.size() == 0) fail_now("a_unexpected_valid");
        else begin
          e = qa.pop_front();
          check("a_rd_data", data_a, e.data);
          check("a_rd_edge", edge_n, e.at);
        end
      end else if (qa.size() > 0 && qa[0].at < edge_n) begin
        e = qa.pop_front();
        fail_now("a_missing_valid");
      end
      if (valid_b) begin
        if (qb.size() == 0) fail_now("b_unexpected_valid");
        else begin
          e = qb.pop_front();
          check("b_rd_data", data_b, e.data);
          check("b_rd_edge", edge_n, e.at);
        end
      end else if (qb.size() > 0 && qb[0].at < edge_n) begin
        e = qb.pop_front();
        fail_now("b_missing_valid");
      end
    end
  endtask

  // One cycle of stimulus; expected read results are queued per instance.
  task automatic op(input bit we, input logic [3:0] be, input logic [3:0] wa,
                    input logic [31:0] wd, input bit re, input logic [3:0] ra,
                    input logic [31:0] ea, input logic [31:0] eb,
                    input bit xa, input bit xb);
    @(negedge clk);
    wr_en = we; wr_be = be; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    if (re && xa) qa.push_back('{ea, edge_n + 1});
    if (re && xb) qb.push_back('{eb, edge_n + 2});
  endtask

  task automatic idle();
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] ra, input logic [31:0] ea, input logic [31:0] eb);
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, ra, ea, eb, 1'b1, 1'b1);
  endtask

  task automatic wr(input logic [3:0] be, input logic [3:0] wa, input logic [31:0] wd);
    op(1'b1, be, wa, wd, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy_a"}, {31'h0, busy_a}, 32'h1);
    check({tag, "_busy_b"}, {31'h0, busy_b}, 32'h1);
    check({tag, "_valid_a"}, {31'h0, valid_a}, 32'h0);
    check({tag, "_valid_b"}, {31'h0, valid_b}, 32'h0);
    check({tag, "_data_a"}, data_a, 32'h0);
    check({tag, "_data_b"}, data_b, 32'h0);
  endtask

  // Release reset and count rising edges until busy drops; optionally poke both ports.
  task automatic release_and_count(input string name, input bit poke);
    int cnt;
    @(negedge clk);
    reset = 1'b0;
    if (poke) begin
      wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd2; wr_data = 32'hFFFF_FFFF;
      rd_en = 1'b1; rd_addr = 4'd2;
    end
    cnt = 0;
    while (busy_a && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(name, cnt, 32'd16);
    check({name, "_b_done"}, {31'h0, busy_b}, 32'h0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) idle();
    check_reset_state("por");

    // Clear with writes/reads attempted throughout; all must be dropped.
    release_and_count("clear_busy_cycles", 1'b1);
    for (int i = 0; i < 16; i++) rd(4'(i), CLR_A, CLR_B);

    // Lane enables.
    wr(4'hF, 4'd3, 32'h1122_3344);
    wr(4'b0101, 4'd3, 32'hAABB_CCDD);
    rd(4'd3, 32'h11BB_33DD, 32'h11BB_33DD);
    wr(4'h0, 4'd0, 32'hFFFF_FFFF);
    rd(4'd0, CLR_A, CLR_B);

    // Read during write, full and partial lanes.
    wr(4'hF, 4'd5, 32'h0000_0010);
    op(1'b1, 4'hF, 4'd5, 32'h0000_0020, 1'b1, 4'd5, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1);
    rd(4'd5, 32'h0000_0020, 32'h0000_0020);
    op(1'b1, 4'h1, 4'd5, 32'hAABB_CC33, 1'b1, 4'd5, 32'h0000_0020, 32'h0000_0033, 1'b1, 1'b1);
    rd(4'd5, 32'h0000_0033, 32'h0000_0033);

    // Different addresses in the same cycle, then the top address.
    op(1'b1, 4'hF, 4'd6, 32'hDEAD_BEEF, 1'b1, 4'd7, CLR_A, CLR_B, 1'b1, 1'b1);
    rd(4'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wr(4'b1000, 4'd15, 32'h1234_5678);
    rd(4'd15, 32'h1200_00A5, 32'h12A5_A5A5);
    repeat (4) idle();

    // Reset while a read is in flight: latency-1 copy completes, latency-2 copy is discarded.
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd4, CLR_A, CLR_B, 1'b1, 1'b0);
    @(negedge clk);
    rd_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("rst_read");

    // Reset again at clear step 7; the clear must restart in full.
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_clear_busy", {31'h0, busy_a}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("rst_clear");
    release_and_count("reclear_busy_cycles", 1'b0);
    rd(4'd5, CLR_A, CLR_B);
    rd(4'd15, CLR_A, CLR_B);
    rd(4'd7, CLR_A, CLR_B);

    for (int i = 0; i < 10 && (qa.size() + qb.size()) != 0; i++) idle();
    repeat (3) idle();
    check("a_queue_drained", qa.size(), 32'd0);
    check("b_queue_drained", qb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_clr.md
# dual_port_ram_clr

Parametrised simple-dual-port RAM: one write port with per-lane byte enables and one independent read port. A hardware clear sequencer fills every location with a constant after reset. Read latency and read-during-write behaviour are selectable. It is the next-generation storage primitive for buffers and register-file style storage, replacing the single-port memory wherever simultaneous read/write or known-clean contents are needed.

## Interface
Parameters:
- DATA_WIDTH, 8: word width in bits; must be an integer multiple of BYTE_WIDTH.
- ADD_WIDTH, 4: address width; DEPTH = 2**ADD_WIDTH words.
- BYTE_WIDTH, 8: lane width; LANES = DATA_WIDTH/BYTE_WIDTH.
- RD_LATENCY, 1: read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0: same-address read during write; 0 = old data (read-first), 1 = new data (write-through).
- CLEAR_VALUE, 0: DATA_WIDTH-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- busy  out  1  high while the clear sequence runs; port requests are ignored.
- wr_en  in  1  write request.
- wr_be  in  LANES  lane enables; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_addr  in  ADD_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADD_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data; holds its last value between reads.
- rd_valid  out  1  one-cycle pulse marking new rd_data.

## Operation
- Illegal parameters (DATA_WIDTH % BYTE_WIDTH != 0, or RD_LATENCY not in {1,2}) stop elaboration with an error.
- FSM states:
  - CLEAR:
    - Entered on every cycle with reset high.
    - While reset is high, clr_cnt = 0 and no memory write occurs.
    - Each cycle with reset low writes CLEAR_VALUE to mem[clr_cnt], then increments clr_cnt.
    - After the write to DEPTH-1, the next state is READY.
  - READY: normal operation. Only reset returns the FSM to CLEAR.
- busy = (state == CLEAR).
- Write, in READY only: when wr_en=1, lane i of mem[wr_addr] is updated only where wr_be[i]=1. If wr_be=0, nothing is written.
- Read, in READY only: rd_en=1 samples rd_addr.
  - After RD_LATENCY cycles, rd_data = mem[rd_addr] and rd_valid=1 for exactly one cycle.
  - With RD_LATENCY=2, the second stage is a pure output register.
- Requests (wr_en, rd_en) while busy=1 are dropped. No rd_valid results from them.
- Read and write to the same address in the same cycle:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word: enabled lanes from wr_data, other lanes from the old word.
- Read and write to different addresses are fully independent.
- Addresses wrap naturally. No out-of-range condition exists.

## Timing
- Reset values: busy=1, rd_valid=0, rd_data=0. All read pipeline valid bits are 0 and all pipeline data registers are 0. State is CLEAR and clr_cnt=0.
- Memory array contents are not reset directly; only the sequencer writes them.
- Let cycle 0 be the first rising edge with reset low. Clear writes occur at cycles 0..DEPTH-1, and busy drops after the edge at cycle DEPTH-1.
- Total: busy stays high for DEPTH cycles after reset is released.
- Reset asserted mid-clear or mid-read:
  - Within one edge: busy=1, rd_valid=0, rd_data=0, and in-flight reads are discarded.
  - The clear then restarts from address 0.
- Read latency: if rd_en is sampled at edge N, rd_data/rd_valid update at edge N+RD_LATENCY.
- Back-to-back reads on consecutive cycles give rd_valid high on consecutive cycles. Throughput is one read and one write per cycle.
- A write at edge N is visible to any read sampled at edge N+1 or later, independent of RDW_MODE.

## Test plan
- Clear: hold reset 3 cycles with DEPTH=16 and CLEAR_VALUE=8'hA5 → busy high for exactly 16 cycles after release; reading all 16 addresses returns 8'hA5 with rd_valid pulses.
- Byte enables (DATA_WIDTH=32, BYTE_WIDTH=8): write 32'h11223344 to addr 3 with wr_be=4'b1111, then 32'hAABBCCDD with wr_be=4'b0101 → read of addr 3 returns 32'h11BB33DD.
- Latency: with RD_LATENCY=1 then 2, issue rd_en at edge N → rd_valid and data appear at edge N+1 and N+2 respectively; 4 back-to-back reads give 4 consecutive rd_valid cycles.
- Read-during-write to addr 5 (old 8'h10, new 8'h20, all lanes enabled) → RDW_MODE=0 returns 8'h10, RDW_MODE=1 returns 8'h20; a read of addr 5 on the next cycle returns 8'h20 in both modes.
- Busy blocking: assert wr_en (addr 2, 8'hFF) and rd_en during the clear → no rd_valid; after the clear, addr 2 reads CLEAR_VALUE.
- Reset mid-operation: assert reset at clear step 7 and while a 2-cycle read is in flight → rd_valid never pulses; busy returns high; the clear restarts and busy stays high for the full 16 cycles.
